// File: rtl/grid_mover_if.sv
// Wall-lookup handshake between the player mover and the map/collision unit.
interface grid_mover_if #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5
);
  logic              wall_req;
  logic [X_BITS-1:0] wall_x;
  logic [Y_BITS-1:0] wall_y;
  logic              wall_ack;
  logic              wall_hit;

  modport master (
    output wall_req, wall_x, wall_y,
    input  wall_ack, wall_hit
  );

  modport slave (
    input  wall_req, wall_x, wall_y,
    output wall_ack, wall_hit
  );
endinterface

// File: rtl/grid_mover.sv
// Player position engine: one bounds- and wall-checked move per frame tick.
module grid_mover #(
  parameter int X_BITS  = 5,
  parameter int Y_BITS  = 5,
  parameter int GRID_W  = 20,
  parameter int GRID_H  = 15,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              frame_tick,
  input  logic [2:0]        move,
  input  logic              move_valid,
  grid_mover_if.master      wall,
  output logic [X_BITS-1:0] x_pos,
  output logic [Y_BITS-1:0] y_pos,
  output logic              moved,
  output logic              blocked,
  output logic              busy,
  output logic [7:0]        move_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_COMMIT,
    S_REJECT
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic              r_pv, w_pv_n;
  logic [2:0]        r_pc, w_pc_n;
  logic [X_BITS-1:0] r_x, w_x_n, r_wx, w_wx_n, w_tx;
  logic [Y_BITS-1:0] r_y, w_y_n, r_wy, w_wy_n, w_ty;
  logic              r_req, w_req_n;
  logic              r_moved, w_moved_n;
  logic              r_blocked, w_blocked_n;
  logic              r_busy;
  logic [7:0]        r_mc, w_mc_n;
  logic              w_oob;
  logic              w_legal;

  assign w_legal = move_valid && (move >= 3'd1) && (move <= 3'd4);

  always_comb begin
    w_tx  = r_x;
    w_ty  = r_y;
    w_oob = 1'b0;
    unique case (1'b1)
      r_pc == 3'd1: begin
        w_ty  = r_y - Y_BITS'(1);
        w_oob = (r_y == '0);
      end
      r_pc == 3'd2: begin
        w_ty  = r_y + Y_BITS'(1);
        w_oob = (r_y == Y_MAX);
      end
      r_pc == 3'd3: begin
        w_tx  = r_x - X_BITS'(1);
        w_oob = (r_x == '0);
      end
      r_pc == 3'd4: begin
        w_tx  = r_x + X_BITS'(1);
        w_oob = (r_x == X_MAX);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_pv_n      = r_pv;
    w_pc_n      = r_pc;
    w_x_n       = r_x;
    w_y_n       = r_y;
    w_wx_n      = r_wx;
    w_wy_n      = r_wy;
    w_req_n     = r_req;
    w_moved_n   = 1'b0;
    w_blocked_n = 1'b0;
    w_mc_n      = r_mc;
    if (w_legal) begin
      w_pv_n = 1'b1;
      w_pc_n = move;
    end
    unique case (r_state)
      S_IDLE: begin
        if (frame_tick && r_pv) begin
          w_wx_n = w_tx;
          w_wy_n = w_ty;
          if (w_oob) begin
            w_state_n = S_REJECT;
          end else begin
            w_state_n = S_QUERY;
            w_req_n   = 1'b1;
            w_cnt_n   = '0;
          end
        end
      end
      S_QUERY: begin
        w_cnt_n = r_cnt + CW'(1);
        // an ack on the last allowed cycle still beats the timeout
        if (wall.wall_ack) begin
          w_req_n   = 1'b0;
          w_state_n = wall.wall_hit ? S_REJECT : S_COMMIT;
        end else if (r_cnt == T_LAST) begin
          w_req_n   = 1'b0;
          w_state_n = S_REJECT;
        end
      end
      S_COMMIT: begin
        w_x_n     = r_wx;
        w_y_n     = r_wy;
        w_mc_n    = r_mc + 8'd1;
        w_moved_n = 1'b1;
        w_state_n = S_IDLE;
        if (!w_legal) w_pv_n = 1'b0;
      end
      S_REJECT: begin
        w_blocked_n = 1'b1;
        w_state_n   = S_IDLE;
        if (!w_legal) w_pv_n = 1'b0;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pv      <= 1'b0;
      r_pc      <= 3'd0;
      r_x       <= X_BITS'(START_X);
      r_y       <= Y_BITS'(START_Y);
      r_wx      <= '0;
      r_wy      <= '0;
      r_req     <= 1'b0;
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
      r_busy    <= 1'b0;
      r_mc      <= 8'd0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_pv      <= w_pv_n;
      r_pc      <= w_pc_n;
      r_x       <= w_x_n;
      r_y       <= w_y_n;
      r_wx      <= w_wx_n;
      r_wy      <= w_wy_n;
      r_req     <= w_req_n;
      r_moved   <= w_moved_n;
      r_blocked <= w_blocked_n;
      r_busy    <= (w_state_n != S_IDLE);
      r_mc      <= w_mc_n;
    end
  end

  assign wall.wall_req = r_req;
  assign wall.wall_x   = r_wx;
  assign wall.wall_y   = r_wy;
  assign x_pos         = r_x;
  assign y_pos         = r_y;
  assign moved         = r_moved;
  assign blocked       = r_blocked;
  assign busy          = r_busy;
  assign move_count    = r_mc;

endmodule

// File: tb/tb_grid_mover.sv
// Randomised bench for grid_mover against a per-move reference model.
module tb_grid_mover;

  localparam int XB = 5;
  localparam int YB = 5;
  localparam int GW = 20;
  localparam int GH = 15;
  localparam int SX = 1;
  localparam int SY = 1;
  localparam int TO = 15;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_tick = 1'b0;
  logic [2:0]    move = 3'd0;
  logic          move_valid = 1'b0;
  logic [XB-1:0] x_pos;
  logic [YB-1:0] y_pos;
  logic          moved;
  logic          blocked;
  logic          busy;
  logic [7:0]    move_count;

  grid_mover_if #(.X_BITS(XB), .Y_BITS(YB)) wif ();

  grid_mover #(
    .X_BITS(XB), .Y_BITS(YB), .GRID_W(GW), .GRID_H(GH),
    .START_X(SX), .START_Y(SY), .TIMEOUT(TO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .move       (move),
    .move_valid (move_valid),
    .wall       (wif),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .moved      (moved),
    .blocked    (blocked),
    .busy       (busy),
    .move_count (move_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_err = 0;
  int mx, my, mc, pend;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_reset();
    mx = SX;
    my = SY;
    mc = 0;
    pend = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_x"}, 32'(x_pos), 32'(mx));
    chk({tag, "_y"}, 32'(y_pos), 32'(my));
    chk({tag, "_cnt"}, 32'(move_count), 32'(mc));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    frame_tick = 1'b0;
    move_valid = 1'b0;
    wif.wall_ack = 1'b0;
    wif.wall_hit = 1'b0;
    step();
    step();
    resetn = 1'b1;
    model_reset();
    check_state("rst");
    chk("rst_req", 32'(wif.wall_req), 0);
    chk("rst_wx", 32'(wif.wall_x), 0);
    chk("rst_wy", 32'(wif.wall_y), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mv", 32'({moved, blocked}), 0);
  endtask

  task automatic send(input int code);
    move_valid = 1'b1;
    move = code[2:0];
    step();
    move_valid = 1'b0;
    if (code >= 1 && code <= 4) pend = code;
  endtask

  task automatic run(input int dly, input bit hit, input bit noack);
    int tx, ty, n;
    bit oob;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (pend == 0) begin
      chk("nop_busy", 32'(busy), 0);
      chk("nop_req", 32'(wif.wall_req), 0);
      step();
      check_state("nop");
      return;
    end
    tx = mx;
    ty = my;
    oob = 1'b0;
    case (pend)
      1: begin oob = (my == 0);      ty = my - 1; end
      2: begin oob = (my == GH - 1); ty = my + 1; end
      3: begin oob = (mx == 0);      tx = mx - 1; end
      default: begin oob = (mx == GW - 1); tx = mx + 1; end
    endcase
    pend = 0;
    chk("busy", 32'(busy), 1);
    if (oob) begin
      chk("oob_req", 32'(wif.wall_req), 0);
      step();
      chk("oob_req2", 32'(wif.wall_req), 0);
      chk("oob_blk", 32'(blocked), 1);
      chk("oob_mv", 32'(moved), 0);
    end else begin
      chk("req", 32'(wif.wall_req), 1);
      chk("wx", 32'(wif.wall_x), 32'(tx));
      chk("wy", 32'(wif.wall_y), 32'(ty));
      if (noack) begin
        n = 0;
        while (wif.wall_req === 1'b1 && n < TO + 10) begin
          n++;
          if ($urandom % 3 == 0) frame_tick = 1'b1;
          step();
          frame_tick = 1'b0;
        end
        chk("to_len", 32'(n), 32'(TO));
        step();
        chk("to_blk", 32'(blocked), 1);
        chk("to_mv", 32'(moved), 0);
      end else begin
        for (int d = 0; d < dly; d++) begin
          if ($urandom % 2 == 0) frame_tick = 1'b1;
          step();
          frame_tick = 1'b0;
          chk("wx_hold", 32'(wif.wall_x), 32'(tx));
          chk("req_hold", 32'(wif.wall_req), 1);
        end
        wif.wall_ack = 1'b1;
        wif.wall_hit = hit;
        step();
        wif.wall_ack = 1'b0;
        wif.wall_hit = 1'b0;
        chk("req_drop", 32'(wif.wall_req), 0);
        step();
        if (!hit) begin
          mx = tx;
          my = ty;
          mc = (mc + 1) % 256;
        end
        chk("res_mv", 32'(moved), 32'(!hit));
        chk("res_blk", 32'(blocked), 32'(hit));
      end
    end
    check_state("res");
    chk("res_busy", 32'(busy), 0);
    step();
    chk("pulse", 32'({moved, blocked}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    wif.wall_ack = 1'b0;
    wif.wall_hit = 1'b0;
    do_reset();

    send(4); run(0, 0, 0);
    send(3); run(0, 0, 0);
    send(3); run(1, 0, 0);
    send(1); run(2, 0, 0);
    send(3); run(0, 0, 0);
    send(1); run(0, 0, 0);
    for (int i = 0; i < GW + 1; i++) begin
      send(4);
      run(0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      send(2);
      run(0, 0, 0);
    end
    send(2); run(4, 1, 0);
    send(2); run(0, 0, 1);
    send(3);
    send(1); send(4); send(7);
    run(0, 0, 0);
    run(0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      int k;
      k = int'($urandom % 4);
      if (k != 0) send(int'($urandom_range(0, 7)));
      if (k == 3) send(int'($urandom_range(0, 7)));
      run(int'($urandom_range(0, 6)), ($urandom % 4) == 0,
          ($urandom % 20) == 0);
    end

    send(4);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("mid_req", 32'(wif.wall_req), 1);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_req", 32'(wif.wall_req), 0);
    chk("arst_busy", 32'(busy), 0);
    check_state("arst");
    step();
    resetn = 1'b1;

    for (int i = 0; i < 256; i++) begin
      send((i % 2 == 0) ? 4 : 3);
      run(int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end
    chk("wrap", 32'(move_count), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/grid_mover.md
# grid_mover

Parametrised player-position engine for the tile-grid games. It holds one player's cell coordinates and accepts keyboard move codes, executing at most one move per frame tick. Before each step it bounds-checks the target cell and asks the map/collision lookup whether the cell is a wall, using a req/ack handshake. It drives the pixel-conversion and HEX display logic downstream and replaces the free-running, unsynchronised position registers of earlier builds.

## Interface
Parameters:
- X_BITS, 5, width of the x coordinate
- Y_BITS, 5, width of the y coordinate
- GRID_W, 20, number of columns; legal x is 0..GRID_W-1, with GRID_W ≤ 2^X_BITS
- GRID_H, 15, number of rows; legal y is 0..GRID_H-1, with GRID_H ≤ 2^Y_BITS
- START_X, 1, x position after reset
- START_Y, 1, y position after reset
- TIMEOUT, 15, cycles to wait for wall_ack before treating the move as blocked; must be ≥ 1

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse, once per frame
- move  in  3  move code: 001 up (y−1), 010 down (y+1), 011 left (x−1), 100 right (x+1); all other codes mean none
- move_valid  in  1  qualifies move for one cycle
- wall_req  out  1  wall lookup request; held high until acknowledged
- wall_x  out  X_BITS  target x; stable while wall_req is high
- wall_y  out  Y_BITS  target y; stable while wall_req is high
- wall_ack  in  1  lookup response is valid this cycle
- wall_hit  in  1  target cell is a wall; sampled only when wall_ack is high
- x_pos  out  X_BITS  current x
- y_pos  out  Y_BITS  current y
- moved  out  1  one-cycle pulse when the position has just changed
- blocked  out  1  one-cycle pulse when a move was rejected
- busy  out  1  high in any state other than IDLE
- move_count  out  8  number of successful moves; wraps from 255 to 0

## Operation
- Reset values: x_pos=START_X, y_pos=START_Y, state IDLE, pending move cleared, wall_req=0, wall_x=0, wall_y=0, moved=0, blocked=0, busy=0, move_count=0.
- Pending register: move_valid with a legal code overwrites the pending move in any state, so the last one received wins. move_valid with an illegal code is ignored.
- States:
  - IDLE:
    - frame_tick with a move pending: compute the target cell and latch it into wall_x/wall_y.
    - If the target is out of bounds (x=0 going left, x=GRID_W−1 going right, y=0 going up, y=GRID_H−1 going down): go to REJECT.
    - Otherwise go to QUERY.
    - frame_tick with nothing pending: no action.
  - QUERY:
    - wall_req=1, and the timeout counter counts from 0.
    - wall_ack with wall_hit=0: go to COMMIT.
    - wall_ack with wall_hit=1: go to REJECT.
    - Counter reaches TIMEOUT with no ack: go to REJECT.
  - COMMIT:
    - Load x_pos/y_pos from the target, increment move_count, pulse moved.
    - Clear the pending move, unless a new move_valid arrives in this same cycle; in that case the new move becomes pending.
    - Go to IDLE.
  - REJECT: pulse blocked, clear the pending move (same exception as COMMIT), go to IDLE.
- frame_tick is ignored while busy. A move that misses its frame waits for the next tick.
- A move_valid in the same cycle as an IDLE frame_tick is not used by that tick. The tick acts on the previously pending move, or does nothing if none was pending.
- Only one coordinate changes per move. Out-of-bounds moves never generate a wall_req.
- A reset assertion in any state, including mid-handshake, immediately forces all reset values. wall_req drops asynchronously.

## Timing
- All outputs are registered.
- frame_tick in cycle t (IDLE, move pending):
  - busy=1 and wall_req=1 from t+1.
  - If wall_ack is high in cycle u ≥ t+1, wall_req drops at u+1.
  - The state is COMMIT or REJECT during u+1.
  - The new x_pos/y_pos, the moved or blocked pulse, and the incremented move_count are all visible in cycle u+2.
  - busy=0 from u+2.
- Best case, with wall_ack in the same cycle as the first wall_req: result at t+3.
- Out of bounds: REJECT during t+1, blocked pulse at t+2.
- Timeout: wall_ack absent through cycle t+TIMEOUT, REJECT during t+TIMEOUT+1, blocked pulse at t+TIMEOUT+2.
- wall_ack while wall_req is low is ignored.
- moved and blocked are never high in the same cycle.
- Back-to-back: the earliest next move begins on the first frame_tick with busy=0.

## Test plan
- Reset with START=(1,1), pending right; pulse frame_tick at t; wall_ack=1, wall_hit=0 at t+1 → at t+3: x_pos=2, y_pos=1, moved=1 for one cycle, move_count=1; wall_x=2, wall_y=1 while wall_req is high.
- At (1,1), pending left then up, repeated to reach (0,0); issue left → blocked pulse 2 cycles after the tick, wall_req never asserts, position stays (0,0). Repeat at x=GRID_W−1 going right → blocked.
- At (5,5), pending down; wall_ack arrives 4 cycles after wall_req rises, with wall_hit=1 → blocked pulse, position stays (5,5), move_count unchanged, frame_ticks during busy are ignored.
- No wall_ack ever (TIMEOUT=15): tick at t → wall_req held high t+1..t+15, blocked pulse at t+17, busy=0 at t+17.
- move_valid with up then right before the tick → only right executes; an illegal code 111 leaves the pending move unchanged; a tick with nothing pending leaves busy=0.
- Assert resetn low while wall_req is high → wall_req=0 immediately, position=(START_X,START_Y), move_count=0; 256 successful moves → move_count wraps to 0.
